chat_gen: RTL and testbench



---
 rtl/chat_pkg.sv | 14 +
 rtl/chat_lfsr.sv | 25 ++
 rtl/chat_gen.sv | 131 +++++++++++++
 tb/tb_chat_gen.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chat_pkg.sv
// Shared types and constants for the chatter generator and its LFSR.
package chat_pkg;

    typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} chat_gen_state_t;

    localparam logic [7:0] LFSR_TAPS     = 8'hB8;
    localparam logic [7:0] DEF_LFSR_SEED = 8'hA5;

    // Feedback bit for x^8+x^6+x^5+x^4+1, shifting towards the MSB.
    function automatic logic lfsr_fb(input logic [7:0] v);
        return ^(v & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/chat_lfsr.sv
// Free-running 8-bit Fibonacci LFSR, falling-edge clocked, synchronous active-high reset to SEED.
module chat_lfsr
    import chat_pkg::*;
#(
    parameter logic [7:0] SEED = DEF_LFSR_SEED
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] lfsr_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    assign lfsr_d = {lfsr_q[6:0], lfsr_fb(lfsr_q)};

    // NOTE: sequential state is always written with <= so every register samples pre-edge values.
    always_ff @(negedge clk) begin
        if (rst) lfsr_q <= SEED;
        else     lfsr_q <= lfsr_d;
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/chat_gen.sv
// Contact-bounce generator: turns a clean level into a burst of pseudo-random toggles.
// Optional burst/toggle statistics ports are enabled by defining CHAT_GEN_STATS_EN.
module chat_gen
    import chat_pkg::*;
#(
    parameter int         HOLD_W     = 3,
    parameter int         SETTLE_CYC = 16,
    parameter logic [7:0] LFSR_SEED  = DEF_LFSR_SEED,
    parameter logic       RST_LEVEL  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clean_in,
    input  logic [3:0] n_bounce,
    output logic       out,
    output logic       busy
`ifdef CHAT_GEN_STATS_EN
    ,
    output logic [15:0] burst_cnt,
    output logic [15:0] tog_cnt
`endif
);

    localparam int IV_W  = HOLD_W + 1;
    localparam int SET_W = $clog2(SETTLE_CYC + 1);

    chat_gen_state_t state_q;
    logic             out_q;
    logic             tgt_q;
    logic             clean_q;
    logic [4:0]       rem_q;
    logic [IV_W-1:0]  ivl_q;
    logic [SET_W-1:0] settle_q;

    logic [7:0]       lfsr;
    logic [IV_W-1:0]  ivl_load;
    logic             settle_done;
    logic             unused_lfsr;

    chat_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .lfsr_o (lfsr)
    );

    // Interval 1..2^HOLD_W; one extra bit keeps 2^HOLD_W from wrapping to zero.
    assign ivl_load    = {1'b0, lfsr[HOLD_W-1:0]} + IV_W'(1);
    assign settle_done = en && (state_q == SETTLE) && (settle_q == SET_W'(SETTLE_CYC - 1));
    assign unused_lfsr = ^lfsr;

    always_ff @(negedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            out_q    <= RST_LEVEL;
            tgt_q    <= RST_LEVEL;
            clean_q  <= RST_LEVEL;
            rem_q    <= '0;
            ivl_q    <= '0;
            settle_q <= '0;
        end else begin
            clean_q <= clean_in;
            if (!en) begin
                state_q <= IDLE;
                out_q   <= clean_q;
                tgt_q   <= clean_q;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (clean_q != tgt_q) begin
                            tgt_q    <= clean_q;
                            out_q    <= clean_q;
                            rem_q    <= {n_bounce, 1'b0};
                            ivl_q    <= ivl_load;
                            settle_q <= '0;
                            // A zero-bounce edge is a single clean transition followed by settling.
                            state_q  <= (n_bounce == 4'd0) ? SETTLE : BOUNCE;
                        end
                    end
                    BOUNCE: begin
                        if (rem_q == 5'd0) begin
                            state_q  <= SETTLE;
                            settle_q <= '0;
                        end else if (ivl_q == IV_W'(1)) begin
                            out_q <= ~out_q;
                            rem_q <= rem_q - 5'd1;
                            ivl_q <= ivl_load;
                            if (rem_q == 5'd1) begin
                                state_q  <= SETTLE;
                                settle_q <= '0;
                            end
                        end else begin
                            ivl_q <= ivl_q - IV_W'(1);
                        end
                    end
                    SETTLE: begin
                        if (settle_done) state_q  <= IDLE;
                        else             settle_q <= settle_q + SET_W'(1);
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign out  = out_q;
    assign busy = (state_q != IDLE);

`ifdef CHAT_GEN_STATS_EN
    logic        out_prev_q;
    logic [15:0] burst_cnt_q;
    logic [15:0] tog_cnt_q;

    // Transitions are counted one edge late by comparing against the previous out level.
    always_ff @(negedge clk) begin
        if (rst) begin
            out_prev_q  <= RST_LEVEL;
            burst_cnt_q <= '0;
            tog_cnt_q   <= '0;
        end else begin
            out_prev_q <= out_q;
            if (out_q != out_prev_q) tog_cnt_q   <= tog_cnt_q + 16'd1;
            if (settle_done)         burst_cnt_q <= burst_cnt_q + 16'd1;
        end
    end

    assign burst_cnt = burst_cnt_q;
    assign tog_cnt   = tog_cnt_q;
`endif

endmodule

// File: tb/tb_chat_gen.sv
// Scoreboard bench for chat_gen: stimulus pushes per-burst expectations, a monitor checks each burst as busy falls.
module tb_chat_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       clean_in = 1'b1;
    logic [3:0] n_bounce = 4'd0;
    logic       out;
    logic       busy;
`ifdef CHAT_GEN_STATS_EN
    logic [15:0] burst_cnt;
    logic [15:0] tog_cnt;
`endif

    always #5 clk = ~clk;

    chat_gen dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clean_in (clean_in),
        .n_bounce (n_bounce),
        .out      (out),
        .busy     (busy)
`ifdef CHAT_GEN_STATS_EN
        ,
        .burst_cnt(burst_cnt),
        .tog_cnt  (tog_cnt)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(negedge clk) cyc++;

    typedef struct {
        bit   chk_cnt;
        int   ntog;
        logic level;
        int   first_cyc;
        bit   after_prev;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input bit chk, input int ntog, input logic level, input int first, input bit after);
        exp_t e;
        e.chk_cnt    = chk;
        e.ntog       = ntog;
        e.level      = level;
        e.first_cyc  = first;
        e.after_prev = after;
        sb.push_back(e);
    endtask

    // Monitor: samples on rising edges, half a cycle away from the DUT's falling-edge updates.
    bit   mon_on     = 1'b0;
    logic prev_out   = 1'b1;
    logic prev_busy  = 1'b0;
    int   tog_n      = 0;
    int   first_tog  = -1;
    int   last_tog   = 0;
    int   last_fall  = -100;
    int   falls      = 0;
    exp_t mon_e;

    always @(posedge clk) begin
        if (mon_on) begin
            if (busy && !prev_busy) begin
                tog_n     = 0;
                first_tog = -1;
            end
            if (busy && out !== prev_out) begin
                if (tog_n > 0) begin
                    n_cmp++;
                    if ((cyc - last_tog) < 1 || (cyc - last_tog) > 8) begin
                        n_fail++;
                        $display("FAIL gap: got %0d cycles, required 1..8 (cycle %0d)", cyc - last_tog, cyc);
                    end
                end else begin
                    first_tog = cyc;
                end
                tog_n++;
                last_tog = cyc;
            end
            if (prev_busy && !busy) begin
                falls++;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_burst: got a burst end, required none (cycle %0d)", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check("final_level", out, mon_e.level);
                    if (mon_e.chk_cnt) begin
                        check("toggles", tog_n, mon_e.ntog);
                        check("settle_len", cyc - last_tog, 16);
                    end
                    if (mon_e.first_cyc >= 0) check("first_latency", first_tog, mon_e.first_cyc);
                    if (mon_e.after_prev)     check("restart_gap", first_tog - last_fall, 1);
                end
                last_fall = cyc;
            end
        end
        prev_out  = out;
        prev_busy = busy;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic wait_falls(input int n, input int budget);
        int tgt;
        @(negedge clk);
        tgt = falls + n;
        for (int i = 0; i < budget && falls < tgt; i++) @(negedge clk);
        if (falls < tgt) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout: got %0d burst ends, required %0d", falls - tgt + n, n);
        end
        @(posedge clk);
    endtask

    task automatic burst(input logic lvl, input logic [3:0] nb, input bit chk, input logic exp_lvl);
        n_bounce = nb;
        clean_in = lvl;
        push(chk, 2 * int'(nb) + 1, exp_lvl, cyc + 2, 1'b0);
    endtask

    initial begin
        int   chg;
        logic prev;
        logic byp_vec [5];
        byp_vec = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset held over two falling edges.
        tick(3);
        check("rst_out", out, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_lfsr", dut.u_lfsr.lfsr_o, 8'hA5);
        rst    = 1'b0;
        en     = 1'b1;
        mon_on = 1'b1;

        // LFSR steps A5 -> 4A -> 95; out stays idle for 100 cycles.
        tick(1);
        check("lfsr_step1", dut.u_lfsr.lfsr_o, 8'h4A);
        tick(1);
        check("lfsr_step2", dut.u_lfsr.lfsr_o, 8'h95);
        chg = 0;
        for (int i = 0; i < 98; i++) begin
            tick(1);
            if (out !== 1'b1 || busy !== 1'b0) chg++;
        end
        check("idle_stable", chg, 0);

        // Zero bounce both directions.
        burst(1'b0, 4'd0, 1'b1, 1'b0);
        wait_falls(1, 600);
        tick(2);
        burst(1'b1, 4'd0, 1'b1, 1'b1);
        wait_falls(1, 600);
        tick(2);

        // Three bounce pairs; n_bounce changed mid-burst must be ignored.
        burst(1'b0, 4'd3, 1'b1, 1'b0);
        tick(3);
        n_bounce = 4'd1;
        wait_falls(1, 600);
        tick(2);
        burst(1'b1, 4'd0, 1'b1, 1'b1);
        wait_falls(1, 600);
        tick(2);

        // Reversal mid-burst restarts one cycle after busy falls.
        burst(1'b0, 4'd5, 1'b1, 1'b0);
        push(1'b1, 11, 1'b1, -1, 1'b1);
        tick(10);
        clean_in = 1'b1;
        wait_falls(2, 1200);
        tick(2);

        // Bypass: out follows clean_in two rising edges after it is driven.
        en = 1'b0;
        tick(2);
        prev = 1'b1;
        foreach (byp_vec[i]) begin
            clean_in = byp_vec[i];
            tick(1);
            check("byp_hold", out, prev);
            tick(1);
            check("byp_out", out, byp_vec[i]);
            check("byp_busy", busy, 1'b0);
            prev = byp_vec[i];
        end

        // Abort by en=0 mid-burst.
        en = 1'b1;
        tick(2);
        burst(1'b0, 4'd4, 1'b0, 1'b0);
        tick(4);
        en = 1'b0;
        tick(1);
        check("abort_out", out, 1'b0);
        check("abort_busy", busy, 1'b0);
        tick(1);
        en = 1'b1;
        tick(2);

        // Reset mid-BOUNCE, then the still-pending clean level starts a fresh burst.
        burst(1'b1, 4'd0, 1'b1, 1'b1);
        wait_falls(1, 600);
        tick(2);
        burst(1'b0, 4'd4, 1'b0, 1'b1);
        tick(4);
        rst = 1'b1;
        tick(1);
        check("rst_mid_out", out, 1'b1);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_lfsr", dut.u_lfsr.lfsr_o, 8'hA5);
        rst = 1'b0;
        push(1'b1, 9, 1'b0, cyc + 2, 1'b0);
        wait_falls(1, 600);
        tick(2);

        // Three n_bounce=2 bursts from a fresh reset, then an aborted one.
        clean_in = 1'b1;
        n_bounce = 4'd0;
        en       = 1'b0;
        tick(3);
        rst = 1'b1;
        en  = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(2);
`ifdef CHAT_GEN_STATS_EN
        check("stats_rst_burst", burst_cnt, 16'd0);
        check("stats_rst_tog", tog_cnt, 16'd0);
`endif
        for (int i = 0; i < 3; i++) begin
            burst((i % 2 == 0) ? 1'b0 : 1'b1, 4'd2, 1'b1, (i % 2 == 0) ? 1'b0 : 1'b1);
            wait_falls(1, 600);
            tick(2);
        end
`ifdef CHAT_GEN_STATS_EN
        check("stats_burst_cnt", burst_cnt, 16'd3);
        check("stats_tog_cnt", tog_cnt, 16'd15);
`endif
        burst(1'b1, 4'd2, 1'b0, 1'b1);
        tick(3);
        en = 1'b0;
        tick(1);
        check("abort2_out", out, 1'b1);
        tick(2);
        en = 1'b1;
        tick(3);
`ifdef CHAT_GEN_STATS_EN
        check("stats_abort_burst_cnt", burst_cnt, 16'd3);
`endif

        tick(5);
        check("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
